steer_quad_multi: RTL and testbench
===================================

Name: steer_quad_multi

Overview:
N-channel digital-joystick-to-quadrature steering encoder. It is the parametrised successor of the single-channel fixed-rate joy2quad. Each channel converts left/right buttons into a 2-bit Gray-coded quadrature pair for the game core's steering inputs, with a programmable start period and a linear acceleration ramp to a top rate. Optional input synchronisers and a clock enable let it sit between the HPS joystick bus and the pixel-rate core clock.

Parameters:
CHANNELS, 2, number of independent steering channels (1..8)
DIV_W, 16, width of divider counter and period registers
DIV_SLOW, 22500, ce-ticks per quadrature step at start of motion
DIV_FAST, 7500, minimum ce-ticks per step (top speed)
RAMP_STEP, 1875, period decrement applied after each emitted step
SYNC_STAGES, 2, flops on left/right inputs (0 = none)

Ports:
CLK  in  1  single clock for all logic
Reset_n  in  1  synchronous, active-low reset
ce  in  1  tick enable; dividers advance only when 1
left  in  CHANNELS  left request per channel, active high
right  in  CHANNELS  right request per channel, active high
steer  out  2*CHANNELS  {A,B} per channel; channel c at [2c+1:2c]
step  out  CHANNELS  one-CLK pulse when channel phase advances
dir  out  2*CHANNELS  per-channel direction state (debug), encoded as in the package

Behaviour:
- Reset (Reset_n=0 at a CLK edge, independent of ce): phase=0 (steer=00), cnt=0, period=DIV_SLOW, dir=IDLE, step=0, sync flops=0.
- Inputs pass through SYNC_STAGES flops. All timing below is relative to the synchronised value.
- Direction decode per channel: right&~left gives RIGHT; left&~right gives LEFT; otherwise IDLE (both pressed = IDLE).
- Phase-to-output Gray map: 0→00, 1→01, 2→11, 3→10. RIGHT increments phase mod 4; LEFT decrements phase mod 4.
- All state updates below occur only on edges with ce=1, except step, which is 0 on every edge unless set by an advance.
- IDLE: cnt←0, period←DIV_SLOW, phase held.
- Direction differs from the registered dir (IDLE→active, or reversal): cnt←0, period←DIV_SLOW, dir updated, no advance that edge.
- Same active direction and cnt==period-1: phase advances, step←1 for one CLK, cnt←0, period←max(period-RAMP_STEP, DIV_FAST). Saturating arithmetic is in DIV_W+1 bits; no underflow.
- Same active direction otherwise: cnt←cnt+1.
- Latency: the first phase change is registered period ce-ticks after the first ce edge that sees the new direction.
- Successive step intervals: DIV_SLOW, DIV_SLOW-RAMP_STEP, …, clamped at DIV_FAST.
- Channels are fully independent; no shared state except CLK, Reset_n and ce.
- Elaboration error if: DIV_FAST<1, DIV_FAST>DIV_SLOW, DIV_SLOW≥2**DIV_W, or CHANNELS outside 1..8.
- steer, step and dir are registered outputs; there is no combinational input→output path.

Decomposition:
- Package steer_quad_pkg: dir_t enum (DIR_IDLE=2'b00, DIR_RIGHT=2'b01, DIR_LEFT=2'b10); function gray_of(phase[1:0]) returning the map above; localparam PHASES=4.
- Sub-module steer_quad_chan: one channel comprising the sync chain, decode, divider, ramp and phase. The top level instantiates it CHANNELS times via generate and packs the outputs.

Test Plan:
All scenarios use DIV_SLOW=8, DIV_FAST=4, RAMP_STEP=2, SYNC_STAGES=0, CHANNELS=2, and ce=1 unless stated.
- Reset: Reset_n=0 for 1 edge with ce=0 → steer=0000, step=00, dir=0000 after that edge.
- Hold right0: step0 pulses at intervals of 8, 6, 4, 4 edges; steer[1:0] sequence is 01, 11, 10, 00.
- Hold left0 from reset: steer[1:0] sequence is 10, 11, 01, 00; intervals 8, 6, 4.
- Reversal after 3 right steps (period=4): switch directly to left → no step for 8 edges, then steer[1:0] returns to the previous Gray code, and the next interval is 6.
- Both pressed for 20 edges → no step, steer held. Then right only → first step after 8 edges.
- ce high every 2nd CLK: intervals double to 16, 12, 8 CLKs. Simultaneously left1 held: ch1 steps independently. Reset_n low mid-ramp → steer=0000 and period back to 8.

Source files
------------

// File: rtl/steer_quad_pkg.sv
// Shared types and helpers for the quadrature steering encoder.
package steer_quad_pkg;

  localparam int PHASES = 4;

  typedef enum logic [1:0] {
    DIR_IDLE  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10
  } dir_t;

  // Phase index to {A,B} Gray code; adjacent phases differ in one bit.
  function automatic logic [1:0] gray_of(input logic [1:0] phase);
    case (phase)
      2'd0:    gray_of = 2'b00;
      2'd1:    gray_of = 2'b01;
      2'd2:    gray_of = 2'b11;
      default: gray_of = 2'b10;
    endcase
  endfunction

endpackage

// File: rtl/steer_quad_chan.sv
// One steering channel: input sync, direction decode, ramped divider, phase.
//
// dir     | meaning
// --------+---------------------------------------------
// IDLE    | no request (or both buttons); divider parked
// RIGHT   | counting towards the next phase increment
// LEFT    | counting towards the next phase decrement
module steer_quad_chan
  import steer_quad_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DIV_SLOW    = 22500,
  parameter int DIV_FAST    = 7500,
  parameter int RAMP_STEP   = 1875,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       ce,
  input  logic       left,
  input  logic       right,
  output logic [1:0] steer,
  output logic       step,
  output logic [1:0] dir
);

  localparam logic [DIV_W-1:0] SLOW_P = DIV_W'(DIV_SLOW);
  localparam logic [DIV_W-1:0] FAST_P = DIV_W'(DIV_FAST);
  localparam logic [DIV_W:0]   RAMP_X = (DIV_W+1)'(RAMP_STEP);
  localparam logic [DIV_W:0]   FAST_X = (DIV_W+1)'(DIV_FAST);

  logic                       left_s, right_s;
  dir_t                       req, dir_q;
  logic [DIV_W-1:0]           cnt, period, next_period;
  logic [DIV_W:0]             period_ext, period_dec;
  logic [$clog2(PHASES)-1:0]  phase, phase_nxt;

  if (SYNC_STAGES > 0) begin : g_sync
    logic [SYNC_STAGES-1:0] l_sync, r_sync;

    // Shift the raw buttons through the synchroniser chain every CLK.
    always_ff @(posedge CLK) begin
      if (!Reset_n) begin
        l_sync <= '0;
        r_sync <= '0;
      end else begin
        l_sync <= (l_sync << 1) | SYNC_STAGES'(left);
        r_sync <= (r_sync << 1) | SYNC_STAGES'(right);
      end
    end

    assign left_s  = l_sync[SYNC_STAGES-1];
    assign right_s = r_sync[SYNC_STAGES-1];
  end else begin : g_nosync
    assign left_s  = left;
    assign right_s = right;
  end

  // Decode the requested direction; both buttons together mean idle.
  always_comb begin
    req = DIR_IDLE;
    if (right_s && !left_s)      req = DIR_RIGHT;
    else if (left_s && !right_s) req = DIR_LEFT;
  end

  assign period_ext = {1'b0, period};
  assign period_dec = period_ext - RAMP_X;
  assign phase_nxt  = (dir_q == DIR_RIGHT) ? phase + 2'd1 : phase - 2'd1;

  // Shorten the period by one ramp step, never below the top-speed period.
  always_comb begin
    next_period = period_dec[DIV_W-1:0];
    if (period_ext < RAMP_X || period_dec < FAST_X) next_period = FAST_P;
  end

  // Divider, ramp and phase state machine; advances only on ce ticks.
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      phase  <= '0;
      steer  <= 2'b00;
      cnt    <= '0;
      period <= SLOW_P;
      dir_q  <= DIR_IDLE;
      step   <= 1'b0;
    end else begin
      step <= 1'b0;
      if (ce) begin
        if (req == DIR_IDLE) begin
          cnt    <= '0;
          period <= SLOW_P;
          dir_q  <= DIR_IDLE;
        end else if (req != dir_q) begin
          cnt    <= '0;
          period <= SLOW_P;
          dir_q  <= req;
        end else if (cnt == period - DIV_W'(1)) begin
          phase  <= phase_nxt;
          steer  <= gray_of(phase_nxt);
          step   <= 1'b1;
          cnt    <= '0;
          period <= next_period;
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end
  end

  assign dir = dir_q;

endmodule

// File: rtl/steer_quad_multi.sv
// N-channel joystick-to-quadrature steering encoder; packs per-channel outputs.
module steer_quad_multi #(
  parameter int CHANNELS    = 2,
  parameter int DIV_W       = 16,
  parameter int DIV_SLOW    = 22500,
  parameter int DIV_FAST    = 7500,
  parameter int RAMP_STEP   = 1875,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  Reset_n,
  input  logic                  ce,
  input  logic [CHANNELS-1:0]   left,
  input  logic [CHANNELS-1:0]   right,
  output logic [2*CHANNELS-1:0] steer,
  output logic [CHANNELS-1:0]   step,
  output logic [2*CHANNELS-1:0] dir
);

  if (DIV_FAST < 1 || DIV_FAST > DIV_SLOW || 64'(DIV_SLOW) >= (64'd1 << DIV_W) ||
      CHANNELS < 1 || CHANNELS > 8) begin : g_bad_params
    $error("steer_quad_multi: illegal parameter combination");
  end

  // One independent channel per steering input.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    steer_quad_chan #(
      .DIV_W      (DIV_W),
      .DIV_SLOW   (DIV_SLOW),
      .DIV_FAST   (DIV_FAST),
      .RAMP_STEP  (RAMP_STEP),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .CLK    (CLK),
      .Reset_n(Reset_n),
      .ce     (ce),
      .left   (left[c]),
      .right  (right[c]),
      .steer  (steer[2*c+1:2*c]),
      .step   (step[c]),
      .dir    (dir[2*c+1:2*c])
    );
  end

endmodule

// File: tb/tb_steer_quad_multi.sv
// Bench for steer_quad_multi: fixed vector table, timing sequences, random run.
module tb_steer_quad_multi;

  localparam int NCH  = 2;
  localparam int SLOW = 8;
  localparam int FAST = 4;
  localparam int RAMP = 2;

  logic             CLK;
  logic             Reset_n;
  logic             ce;
  logic [NCH-1:0]   left, right;
  logic [2*NCH-1:0] steer, dir;
  logic [NCH-1:0]   step;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: elapsed ticks since last step/direction start.
  int   m_phase[NCH];
  int   m_elapsed[NCH];
  int   m_period[NCH];
  int   m_dir[NCH];     // 0 idle, 1 right, 2 left
  logic m_step[NCH];
  int   gray_tab[4] = '{0, 1, 3, 2};

  steer_quad_multi #(
    .CHANNELS(NCH), .DIV_W(16), .DIV_SLOW(SLOW), .DIV_FAST(FAST),
    .RAMP_STEP(RAMP), .SYNC_STAGES(0)
  ) dut (
    .CLK(CLK), .Reset_n(Reset_n), .ce(ce), .left(left), .right(right),
    .steer(steer), .step(step), .dir(dir)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rb, input logic c,
                            input logic [NCH-1:0] l, input logic [NCH-1:0] r);
    for (int ch = 0; ch < NCH; ch++) begin
      int d;
      if (!rb) begin
        m_phase[ch] = 0; m_elapsed[ch] = 0; m_period[ch] = SLOW;
        m_dir[ch] = 0; m_step[ch] = 1'b0;
      end else begin
        m_step[ch] = 1'b0;
        if (c) begin
          d = (r[ch] && !l[ch]) ? 1 : (l[ch] && !r[ch]) ? 2 : 0;
          if (d == 0 || d != m_dir[ch]) begin
            m_dir[ch] = d; m_period[ch] = SLOW; m_elapsed[ch] = 0;
          end else begin
            m_elapsed[ch]++;
            if (m_elapsed[ch] == m_period[ch]) begin
              m_phase[ch]   = (m_phase[ch] + (d == 1 ? 1 : 3)) % 4;
              m_step[ch]    = 1'b1;
              m_elapsed[ch] = 0;
              m_period[ch]  = (m_period[ch] - RAMP < FAST) ? FAST : m_period[ch] - RAMP;
            end
          end
        end
      end
    end
  endtask

  task automatic check_model();
    logic [9:0] exp;
    exp = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      exp[2*ch +: 2]     = gray_tab[m_phase[ch]][1:0];
      exp[4 + ch]        = m_step[ch];
      exp[6 + 2*ch +: 2] = m_dir[ch][1:0];
    end
    chk("model {dir,step,steer}", {22'd0, dir, step, steer}, {22'd0, exp});
  endtask

  task automatic do_edge(input logic rb, input logic c,
                         input logic [NCH-1:0] l, input logic [NCH-1:0] r);
    Reset_n = rb; ce = c; left = l; right = r;
    @(posedge CLK);
    model_step(rb, c, l, r);
    #1;
    check_model();
  endtask

  typedef struct {
    logic       rb;
    logic       c;
    logic [1:0] l;
    logic [1:0] r;
    int         n;
    logic [3:0] steer;
    logic [1:0] step;
    logic [3:0] dir;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int         t0[$];
    int         t1[$];
    logic [3:0] s0[$];
    int         exp_t[3];
    logic [3:0] exp_s[3];
    int         first;
    logic [1:0] rl, rr;

    Reset_n = 1'b0; ce = 1'b0; left = '0; right = '0;

    //          rb    ce    left   right  n   steer    step   dir
    tbl[0]  = '{1'b0, 1'b0, 2'b00, 2'b00, 1,  4'b0000, 2'b00, 4'b0000};
    tbl[1]  = '{1'b1, 1'b1, 2'b00, 2'b01, 1,  4'b0000, 2'b00, 4'b0001};
    tbl[2]  = '{1'b1, 1'b1, 2'b00, 2'b01, 7,  4'b0000, 2'b00, 4'b0001};
    tbl[3]  = '{1'b1, 1'b1, 2'b00, 2'b01, 1,  4'b0001, 2'b01, 4'b0001};
    tbl[4]  = '{1'b1, 1'b1, 2'b00, 2'b01, 5,  4'b0001, 2'b00, 4'b0001};
    tbl[5]  = '{1'b1, 1'b1, 2'b00, 2'b01, 1,  4'b0011, 2'b01, 4'b0001};
    tbl[6]  = '{1'b1, 1'b1, 2'b00, 2'b01, 3,  4'b0011, 2'b00, 4'b0001};
    tbl[7]  = '{1'b1, 1'b1, 2'b00, 2'b01, 1,  4'b0010, 2'b01, 4'b0001};
    tbl[8]  = '{1'b1, 1'b1, 2'b01, 2'b00, 1,  4'b0010, 2'b00, 4'b0010};
    tbl[9]  = '{1'b1, 1'b1, 2'b01, 2'b00, 7,  4'b0010, 2'b00, 4'b0010};
    tbl[10] = '{1'b1, 1'b1, 2'b01, 2'b00, 1,  4'b0011, 2'b01, 4'b0010};
    tbl[11] = '{1'b1, 1'b1, 2'b01, 2'b00, 5,  4'b0011, 2'b00, 4'b0010};
    tbl[12] = '{1'b1, 1'b1, 2'b01, 2'b00, 1,  4'b0001, 2'b01, 4'b0010};
    tbl[13] = '{1'b1, 1'b1, 2'b01, 2'b01, 20, 4'b0001, 2'b00, 4'b0000};
    tbl[14] = '{1'b1, 1'b1, 2'b00, 2'b01, 8,  4'b0001, 2'b00, 4'b0001};
    tbl[15] = '{1'b1, 1'b1, 2'b00, 2'b01, 1,  4'b0011, 2'b01, 4'b0001};

    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < tbl[i].n; k++)
        do_edge(tbl[i].rb, tbl[i].c, tbl[i].l, tbl[i].r);
      chk($sformatf("vec%0d steer", i), {28'd0, steer}, {28'd0, tbl[i].steer});
      chk($sformatf("vec%0d step", i),  {30'd0, step},  {30'd0, tbl[i].step});
      chk($sformatf("vec%0d dir", i),   {28'd0, dir},   {28'd0, tbl[i].dir});
    end

    // Half-rate ce, right0 and left1 held together from a clean reset.
    do_edge(1'b0, 1'b0, 2'b00, 2'b00);
    for (int k = 0; k < 46; k++) begin
      do_edge(1'b1, (k % 2) == 0, 2'b10, 2'b01);
      if (step[0]) begin t0.push_back(k); s0.push_back(steer); end
      if (step[1]) t1.push_back(k);
    end
    exp_t = '{16, 28, 36};
    exp_s = '{4'b1001, 4'b1111, 4'b0110};
    chk("half-rate ch0 step count >= 3", {31'd0, t0.size() >= 3}, 32'd1);
    chk("half-rate ch1 step count >= 3", {31'd0, t1.size() >= 3}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (i < t0.size()) begin
        chk($sformatf("half-rate ch0 step%0d time", i), t0[i], exp_t[i]);
        chk($sformatf("half-rate steer at step%0d", i), {28'd0, s0[i]}, {28'd0, exp_s[i]});
      end
      if (i < t1.size())
        chk($sformatf("half-rate ch1 step%0d time", i), t1[i], exp_t[i]);
    end

    // Reset in the middle of the ramp restarts at the slow period.
    do_edge(1'b0, 1'b0, 2'b10, 2'b01);
    chk("mid-ramp reset steer", {28'd0, steer}, 32'd0);
    first = -1;
    for (int k = 0; k < 20; k++) begin
      do_edge(1'b1, (k % 2) == 0, 2'b10, 2'b01);
      if (step[0] && first < 0) first = k;
    end
    chk("mid-ramp reset first step", first, 16);

    // Random buttons, ce and occasional reset against the reference model.
    do_edge(1'b0, 1'b0, 2'b00, 2'b00);
    rl = 2'b00; rr = 2'b00;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 29) == 0) rl = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) rr = 2'($urandom_range(0, 3));
      do_edge($urandom_range(0, 499) != 0, $urandom_range(0, 3) != 0, rl, rr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
